// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - multiplexed N-digit hex display scanner
// Latches a packed hex value and time-multiplexes it onto a shared a..g bus with one-hot digit enables.
module seven_segment_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int GUARD      = 16,
    parameter int SYNC_LOAD  = 1,
    parameter int LZ_BLANK   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset_a,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic                  pend_v_q, pend_v_d;
    logic                  blank_q;
    logic                  frame_done_q;
    logic                  active_q;

    logic                  slot_end, last_digit, wrap;
    logic [NUM_DIGITS-1:0] lit;
    logic                  any_nz;
    logic [3:0]            cur_digit;
    logic                  show;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h7E;  4'h1: font = 7'h30;  4'h2: font = 7'h6D;  4'h3: font = 7'h79;
            4'h4: font = 7'h33;  4'h5: font = 7'h5B;  4'h6: font = 7'h5F;  4'h7: font = 7'h70;
            4'h8: font = 7'h7F;  4'h9: font = 7'h7B;  4'hA: font = 7'h77;  4'hB: font = 7'h1F;
            4'hC: font = 7'h4E;  4'hD: font = 7'h3D;  4'hE: font = 7'h4F;  default: font = 7'h47;
        endcase
    endfunction

    assign slot_end   = (cnt_q == CW'(SCAN_DIV - 1));
    assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
    assign wrap       = slot_end && last_digit;

    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) idx_d = last_digit ? '0 : idx_q + 1'b1;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        if (SYNC_LOAD == 0) begin
            if (load) shadow_d = value;
        end else if (load && wrap) begin
            shadow_d = value;
            pend_v_d = 1'b0;
        end else if (load) begin
            pending_d = value;
            pend_v_d  = 1'b1;
        end else if (wrap && pend_v_q) begin
            shadow_d = pending_q;
            pend_v_d = 1'b0;
        end
    end

    // A digit stays lit if it or any more significant digit is nonzero; digit 0 always lit.
    always_comb begin
        lit    = '0;
        any_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            any_nz = any_nz | (shadow_q[4*k +: 4] != 4'h0);
            lit[k] = any_nz || (k == 0) || (LZ_BLANK == 0);
        end
    end

    assign cur_digit = shadow_q[4*idx_q +: 4];
    // active_q keeps the pins dark while in reset even when GUARD is 0.
    assign show      = active_q && (cnt_q >= CW'(GUARD)) && !blank_q && lit[idx_q];
    assign seg_raw   = show ? font(cur_digit) : 7'h00;
    assign dig_raw   = show ? (NUM_DIGITS'(1) << idx_q) : '0;

    assign seg        = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign dig_en     = (ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            blank_q      <= 1'b0;
            frame_done_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            blank_q      <= blank;
            frame_done_q <= wrap;
            active_q     <= 1'b1;
        end
    end

endmodule
